mc_sequencer: RTL and testbench

// - Multi-cycle control FSM for the RV32I-subset core. It replaces the single-cycle decode with a

---
 rtl/mc_sequencer_if.sv | 21 ++
 rtl/mc_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_sequencer_if.sv
// rtl/mc_sequencer_if.sv - shared instruction/data memory request handshake
interface mc_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic adr_src;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output adr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  adr_src,
        output mem_ready
    );
endinterface

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multi-cycle RV32I-subset control FSM over one shared memory port
// Optional MC_SEQ_PERF_EN adds cycle/instret performance counters.
module mc_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr_i,
    input  logic              eq_i,
    mc_sequencer_if.master    mem,
    output logic              pc_en_o,
    output logic              ir_en_o,
    output logic              reg_write_o,
    output logic [1:0]        alu_src_a_o,
    output logic [1:0]        alu_src_b_o,
    output logic [1:0]        result_src_o,
    output logic [1:0]        imm_src_o,
    output logic [2:0]        alu_ctrl_o,
    output logic              retire_o,
`ifdef MC_SEQ_PERF_EN
    output logic [PERF_W-1:0] cycle_cnt_o,
    output logic [PERF_W-1:0] instret_cnt_o,
`endif
    output logic              trap_o
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] TMO_LAST =
        (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    if (PERF_W < 1) begin : g_perf_w_chk
        $error("PERF_W must be at least 1");
    end

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       tmo_hit;
    logic       unused_instr;

    assign op           = instr_i[6:0];
    assign funct3       = instr_i[14:12];
    assign funct7b5     = instr_i[30];
    assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};
    assign tmo_hit      = (MEM_TIMEOUT != 0) && (wait_q == TMO_LAST);

    function automatic logic [2:0] alu_map(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_map = sub ? 3'b001 : 3'b000;
            3'b111:  alu_map = 3'b010;
            3'b110:  alu_map = 3'b011;
            3'b100:  alu_map = 3'b100;
            3'b010:  alu_map = 3'b101;
            3'b001:  alu_map = 3'b110;
            3'b101:  alu_map = 3'b111;
            default: alu_map = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Outputs are forced low while rst_n is low so an in-flight request drops at once.
    always_comb begin
        state_d      = state_q;
        pc_en_o      = 1'b0;
        ir_en_o      = 1'b0;
        mem.adr_src  = 1'b0;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        result_src_o = 2'b00;
        imm_src_o    = 2'b00;
        alu_ctrl_o   = 3'b000;
        retire_o     = 1'b0;
        trap_o       = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem.mem_req = 1'b1;
                    if (mem.mem_ready) begin
                        ir_en_o      = 1'b1;
                        pc_en_o      = 1'b1;
                        alu_src_b_o  = 2'b10;
                        result_src_o = 2'b10;
                        state_d      = S_DECODE;
                    end else if (tmo_hit) begin
                        state_d = S_TRAP;
                    end
                end
                S_DECODE: begin
                    alu_src_a_o = 2'b01;
                    alu_src_b_o = 2'b01;
                    imm_src_o   = 2'b10;
                    case (op)
                        7'b0000011, 7'b0100011: state_d = S_MEMADR;
                        7'b0110011:             state_d = S_EXEC_R;
                        7'b0010011:             state_d = S_EXEC_I;
                        7'b1100011:             state_d = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
                        7'b1101111:             state_d = S_JAL;
                        default:                state_d = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a_o = 2'b10;
                    alu_src_b_o = 2'b01;
                    imm_src_o   = op[5] ? 2'b01 : 2'b00;
                    state_d     = op[5] ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    mem.mem_req = 1'b1;
                    mem.adr_src = 1'b1;
                    if (mem.mem_ready)  state_d = S_MEMWB;
                    else if (tmo_hit)   state_d = S_TRAP;
                end
                S_MEMWB: begin
                    result_src_o = 2'b01;
                    reg_write_o  = 1'b1;
                    retire_o     = 1'b1;
                    state_d      = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem.mem_req = 1'b1;
                    mem.mem_we  = 1'b1;
                    mem.adr_src = 1'b1;
                    if (mem.mem_ready) begin
                        retire_o = 1'b1;
                        state_d  = S_FETCH;
                    end else if (tmo_hit) begin
                        state_d = S_TRAP;
                    end
                end
                S_EXEC_R: begin
                    alu_src_a_o = 2'b10;
                    alu_ctrl_o  = alu_map(funct3, funct7b5);
                    state_d     = S_ALUWB;
                end
                S_EXEC_I: begin
                    alu_src_a_o = 2'b10;
                    alu_src_b_o = 2'b01;
                    alu_ctrl_o  = alu_map(funct3, 1'b0);
                    state_d     = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write_o = 1'b1;
                    retire_o    = 1'b1;
                    state_d     = S_FETCH;
                end
                S_BEQ: begin
                    alu_src_a_o = 2'b10;
                    alu_ctrl_o  = 3'b001;
                    pc_en_o     = eq_i;
                    retire_o    = 1'b1;
                    state_d     = S_FETCH;
                end
                S_JAL: begin
                    alu_src_a_o = 2'b01;
                    alu_src_b_o = 2'b10;
                    pc_en_o     = 1'b1;
                    reg_write_o = 1'b1;
                    retire_o    = 1'b1;
                    state_d     = S_FETCH;
                end
                S_TRAP: begin
                    trap_o = 1'b1;
                end
                default: state_d = S_TRAP;
            endcase
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q)
            wait_d = '0;
        else if (mem.mem_req && !mem.mem_ready)
            wait_d = wait_q + 1'b1;
    end

`ifdef MC_SEQ_PERF_EN
    logic [PERF_W-1:0] cycle_q, instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_q + 1'b1;
            instret_q <= instret_q + {{(PERF_W-1){1'b0}}, retire_o};
        end
    end

    assign cycle_cnt_o   = cycle_q;
    assign instret_cnt_o = instret_q;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - scoreboard bench for the multi-cycle control sequencer
module tb_mc_sequencer;

`ifdef MC_SEQ_PERF_EN
    localparam int PW = 4;
`else
    localparam int PW = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        eq = 1'b0;
    logic        pc_en, ir_en, reg_write, retire, trap;
    logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0]  alu_ctrl;
`ifdef MC_SEQ_PERF_EN
    logic [PW-1:0] cycle_cnt, instret_cnt;
    logic [PW-1:0] cyc_model = '0;
`endif

    mc_sequencer_if mif ();

    mc_sequencer #(.MEM_TIMEOUT(16), .PERF_W(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_i      (instr),
        .eq_i         (eq),
        .mem          (mif.master),
        .pc_en_o      (pc_en),
        .ir_en_o      (ir_en),
        .reg_write_o  (reg_write),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .result_src_o (result_src),
        .imm_src_o    (imm_src),
        .alu_ctrl_o   (alu_ctrl),
        .retire_o     (retire),
`ifdef MC_SEQ_PERF_EN
        .cycle_cnt_o  (cycle_cnt),
        .instret_cnt_o(instret_cnt),
`endif
        .trap_o       (trap)
    );

    always #5 clk = ~clk;

    // {pc_en, ir_en, adr_src, mem_req, mem_we, reg_write, A, B, result, imm, alu, retire, trap}
    logic [18:0] act;
    assign act = {pc_en, ir_en, mif.adr_src, mif.mem_req, mif.mem_we, reg_write,
                  alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, retire, trap};

    localparam logic [18:0] V_ZERO    = 19'b0;
    localparam logic [18:0] V_F_WAIT  = {6'b000100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [18:0] V_F_RDY   = {6'b110100, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 2'b00};
    localparam logic [18:0] V_DEC     = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000, 2'b00};
    localparam logic [18:0] V_EXR_ADD = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [18:0] V_EXR_SUB = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 2'b00};
    localparam logic [18:0] V_EXI_XOR = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 3'b100, 2'b00};
    localparam logic [18:0] V_ALUWB   = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10};
    localparam logic [18:0] V_MA_L    = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [18:0] V_MA_S    = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000, 2'b00};
    localparam logic [18:0] V_MR      = {6'b001100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [18:0] V_MWB     = {6'b000001, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 2'b10};
    localparam logic [18:0] V_MW_WAIT = {6'b001110, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [18:0] V_MW_RDY  = {6'b001110, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10};
    localparam logic [18:0] V_BEQ_T   = {6'b100000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 2'b10};
    localparam logic [18:0] V_BEQ_N   = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 2'b10};
    localparam logic [18:0] V_JAL     = {6'b100001, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 2'b10};
    localparam logic [18:0] V_TRAP    = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01};

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_XORI = 32'h0050C193;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_BNE  = 32'h00209063;
    localparam logic [31:0] I_JAL  = 32'h0000006F;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    int n_chk  = 0;
    int n_pass = 0;
    int ret_model = 0;

    logic [18:0] sb_v[$];
    string       sb_tag[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc(input logic [31:0] ins, input logic rdy, input logic e,
                       input logic [18:0] exp, input string tag);
        @(posedge clk);
        #1;
        instr         = ins;
        mif.mem_ready = rdy;
        eq            = e;
        sb_v.push_back(exp);
        sb_tag.push_back(tag);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst_n         = 1'b0;
        mif.mem_ready = 1'b0;
        #1;
        check_eq("reset_outputs_zero", {13'b0, act}, {13'b0, V_ZERO});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("post_reset_fetch", {13'b0, act}, {13'b0, V_F_WAIT});
    endtask

    always @(negedge clk) begin
        if (!rst_n) ret_model = 0;
        if (sb_v.size() > 0) begin
            logic [18:0] e;
            string       t;
            e = sb_v.pop_front();
            t = sb_tag.pop_front();
            if (e[1]) ret_model++;
            check_eq(t, {13'b0, act}, {13'b0, e});
        end
    end

`ifdef MC_SEQ_PERF_EN
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_model <= '0;
        else        cyc_model <= cyc_model + 1'b1;
    end
`endif

    initial begin
        mif.mem_ready = 1'b0;
        #12;
        check_eq("reset_outputs_zero", {13'b0, act}, {13'b0, V_ZERO});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("post_reset_fetch", {13'b0, act}, {13'b0, V_F_WAIT});

        // ADD with ready also asserted outside requests
        cyc(I_ADD, 1'b1, 1'b0, V_F_RDY,   "add_fetch");
        cyc(I_ADD, 1'b1, 1'b0, V_DEC,     "add_decode");
        cyc(I_ADD, 1'b1, 1'b0, V_EXR_ADD, "add_exec_r");
        cyc(I_ADD, 1'b1, 1'b0, V_ALUWB,   "add_aluwb");

        // ready on the last allowed wait cycle beats the timeout
        for (int i = 0; i < 15; i++) cyc(I_SUB, 1'b0, 1'b0, V_F_WAIT, "sub_fetch_wait");
        cyc(I_SUB, 1'b1, 1'b0, V_F_RDY,   "sub_fetch_last_ready");
        cyc(I_SUB, 1'b0, 1'b0, V_DEC,     "sub_decode");
        cyc(I_SUB, 1'b0, 1'b0, V_EXR_SUB, "sub_exec_r");
        cyc(I_SUB, 1'b0, 1'b0, V_ALUWB,   "sub_aluwb");

        cyc(I_XORI, 1'b1, 1'b0, V_F_RDY,   "xori_fetch");
        cyc(I_XORI, 1'b0, 1'b0, V_DEC,     "xori_decode");
        cyc(I_XORI, 1'b0, 1'b0, V_EXI_XOR, "xori_exec_i");
        cyc(I_XORI, 1'b0, 1'b0, V_ALUWB,   "xori_aluwb");

        cyc(I_LW, 1'b1, 1'b0, V_F_RDY, "lw_fetch");
        cyc(I_LW, 1'b0, 1'b0, V_DEC,   "lw_decode");
        cyc(I_LW, 1'b0, 1'b0, V_MA_L,  "lw_memadr");
        for (int i = 0; i < 3; i++) cyc(I_LW, 1'b0, 1'b0, V_MR, "lw_memread_wait");
        cyc(I_LW, 1'b1, 1'b0, V_MR,    "lw_memread_ready");
        cyc(I_LW, 1'b0, 1'b0, V_MWB,   "lw_memwb");

        cyc(I_SW, 1'b1, 1'b0, V_F_RDY,   "sw_fetch");
        cyc(I_SW, 1'b0, 1'b0, V_DEC,     "sw_decode");
        cyc(I_SW, 1'b0, 1'b0, V_MA_S,    "sw_memadr");
        cyc(I_SW, 1'b0, 1'b0, V_MW_WAIT, "sw_memwrite_wait");
        cyc(I_SW, 1'b1, 1'b0, V_MW_RDY,  "sw_memwrite_ready");

        cyc(I_BEQ, 1'b1, 1'b1, V_F_RDY, "beq_t_fetch");
        cyc(I_BEQ, 1'b0, 1'b1, V_DEC,   "beq_t_decode");
        cyc(I_BEQ, 1'b0, 1'b1, V_BEQ_T, "beq_taken");
        cyc(I_BEQ, 1'b1, 1'b0, V_F_RDY, "beq_n_fetch");
        cyc(I_BEQ, 1'b0, 1'b0, V_DEC,   "beq_n_decode");
        cyc(I_BEQ, 1'b0, 1'b0, V_BEQ_N, "beq_not_taken");

        cyc(I_JAL, 1'b1, 1'b0, V_F_RDY, "jal_fetch");
        cyc(I_JAL, 1'b0, 1'b0, V_DEC,   "jal_decode");
        cyc(I_JAL, 1'b0, 1'b0, V_JAL,   "jal_exec");

        // reset in the middle of a pending fetch request
        cyc(I_ADD, 1'b0, 1'b0, V_F_WAIT, "midreq_fetch_wait");
        cyc(I_ADD, 1'b0, 1'b0, V_F_WAIT, "midreq_fetch_wait");
        pulse_reset();

        cyc(I_BNE, 1'b1, 1'b0, V_F_RDY, "bne_fetch");
        cyc(I_BNE, 1'b0, 1'b0, V_DEC,   "bne_decode");
        cyc(I_BNE, 1'b0, 1'b0, V_TRAP,  "bne_trap");
        pulse_reset();

        cyc(I_BAD, 1'b1, 1'b0, V_F_RDY, "badop_fetch");
        cyc(I_BAD, 1'b0, 1'b0, V_DEC,   "badop_decode");
        cyc(I_BAD, 1'b0, 1'b0, V_TRAP,  "badop_trap");
        cyc(I_BAD, 1'b1, 1'b0, V_TRAP,  "badop_trap_sticky");
        pulse_reset();

        // full timeout: the wait cycle already spent right after reset counts
        for (int i = 0; i < 15; i++) cyc(I_ADD, 1'b0, 1'b0, V_F_WAIT, "tmo_fetch_wait");
        cyc(I_ADD, 1'b1, 1'b0, V_TRAP, "tmo_trap");
        cyc(I_ADD, 1'b1, 1'b0, V_TRAP, "tmo_trap_sticky");
        pulse_reset();

        cyc(I_ADD, 1'b1, 1'b0, V_F_RDY,   "post_trap_fetch");
        cyc(I_ADD, 1'b0, 1'b0, V_DEC,     "post_trap_decode");
        cyc(I_ADD, 1'b0, 1'b0, V_EXR_ADD, "post_trap_exec_r");
        cyc(I_ADD, 1'b0, 1'b0, V_ALUWB,   "post_trap_aluwb");
        for (int i = 0; i < 17; i++) begin
            cyc(I_JAL, 1'b1, 1'b0, V_F_RDY, "perf_jal_fetch");
            cyc(I_JAL, 1'b0, 1'b0, V_DEC,   "perf_jal_decode");
            cyc(I_JAL, 1'b0, 1'b0, V_JAL,   "perf_jal_exec");
        end

        @(negedge clk);
        @(posedge clk);
        #1;
        check_eq("scoreboard_drained", sb_v.size(), 0);
`ifdef MC_SEQ_PERF_EN
        check_eq("cycle_cnt", {{(32-PW){1'b0}}, cycle_cnt}, {{(32-PW){1'b0}}, cyc_model});
        check_eq("instret_cnt", {{(32-PW){1'b0}}, instret_cnt}, 32'(ret_model % 16));
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
